instr_fetch_buffer: RTL and testbench

//  Fetch stage directly downstream of the PC register. Takes the current Pc and issues word reads to a

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch_buffer.sv | 80 ++++++++
 tb/tb_instr_fetch_buffer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: default widths, the NOP encoding and the
// {pc, instr} entry layout queued between fetch and decode.
package mips_pkg;

    parameter int unsigned ADDR_W = 32;
    parameter int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries; head is read straight from
// registered storage. Clear has priority over push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues word reads for the current PC, pairs each 1-cycle-latency
// response with its PC and queues it for decode; flush discards wrong-path work.
module instr_fetch_buffer
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              misalign_err
);

    localparam int unsigned EW = ADDR_W + DATA_W;

    logic                    inflight_q;
    logic [ADDR_W-1:0]       req_pc_q;
    logic                    misalign_q;
    logic [$clog2(DEPTH):0]  count;
    logic [31:0]             occupancy;
    logic                    push;
    logic                    pop;
    logic [EW-1:0]           head;

    // Outstanding memory read counts against capacity so its response always has a slot.
    assign occupancy = 32'(count) + 32'(inflight_q);
    assign imem_req  = rst_n & ~flush & (occupancy < DEPTH);
    assign imem_addr = {pc[ADDR_W-1:2], 2'b00};
    assign pc_en     = imem_req | flush;

    assign push = inflight_q & ~flush;
    assign pop  = instr_valid & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                req_pc_q <= pc;
            end
            if (imem_req && (pc[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({req_pc_q, imem_rdata}),
        .rdata (head),
        .count (count)
    );

    assign instr_valid  = (count != '0);
    assign instr_pc     = head[EW-1:DATA_W];
    assign instr        = head[DATA_W-1:0];
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a behavioural PC register and a
// 1-cycle-latency instruction memory returning addr ^ 0xA5A5_0000.
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_err;

    logic [31:0] pc_rst;
    logic [31:0] redirect;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] XORV = 32'hA5A5_0000;

    always #5 clk = ~clk;

    instr_fetch_buffer #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .pc_en        (pc_en),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .misalign_err (misalign_err)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= pc_rst;
        else if (pc_en) pc <= flush ? redirect : pc + 32'd4;
    end

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ XORV;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        @(negedge clk);
        pc_rst      = start_pc;
        rst_n       = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    // One cycle: drive inputs at negedge (releasing reset), then check outputs.
    task automatic step(input string tag, input logic f, input logic r,
                        input logic e_req, input logic e_pcen, input logic [31:0] e_addr,
                        input logic e_valid, input logic [31:0] e_ipc);
        @(negedge clk);
        rst_n       = 1'b1;
        flush       = f;
        instr_ready = r;
        #1;
        check({tag, ".req"}, 32'(imem_req), 32'(e_req));
        check({tag, ".pcen"}, 32'(pc_en), 32'(e_pcen));
        if (e_req) check({tag, ".addr"}, imem_addr, e_addr);
        check({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
        if (e_valid) begin
            check({tag, ".ipc"}, instr_pc, e_ipc);
            check({tag, ".instr"}, instr, {e_ipc[31:2], 2'b00} ^ XORV);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        pc_rst      = 32'h0;
        redirect    = 32'h100;

        // Reset state with a nonzero PC present.
        do_reset(32'h40);
        check("rst.req", 32'(imem_req), 32'd0);
        check("rst.pcen", 32'(pc_en), 32'd0);
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.instr", instr, 32'h0);
        check("rst.ipc", instr_pc, 32'h0);
        check("rst.mis", 32'(misalign_err), 32'd0);

        // Stream with ready high: a request is withheld while one is queued and one in flight.
        do_reset(32'h0);
        step("s0", 0, 1, 1, 1, 32'h0,  0, 32'h0);
        step("s1", 0, 1, 1, 1, 32'h4,  0, 32'h0);
        step("s2", 0, 1, 0, 0, 32'h0,  1, 32'h0);
        step("s3", 0, 1, 1, 1, 32'h8,  1, 32'h4);
        step("s4", 0, 1, 1, 1, 32'hC,  0, 32'h0);
        step("s5", 0, 1, 0, 0, 32'h0,  1, 32'h8);
        step("s6", 0, 1, 1, 1, 32'h10, 1, 32'hC);
        check("s.mis", 32'(misalign_err), 32'd0);

        // Backpressure: fill, hold, then drain in order and resume at 8.
        do_reset(32'h0);
        step("b0", 0, 0, 1, 1, 32'h0, 0, 32'h0);
        step("b1", 0, 0, 1, 1, 32'h4, 0, 32'h0);
        step("b2", 0, 0, 0, 0, 32'h0, 1, 32'h0);
        step("b3", 0, 0, 0, 0, 32'h0, 1, 32'h0);
        check("b3.pc", pc, 32'h8);
        step("b4", 0, 0, 0, 0, 32'h0, 1, 32'h0);
        step("b5", 0, 1, 0, 0, 32'h0, 1, 32'h0);
        step("b6", 0, 1, 1, 1, 32'h8, 1, 32'h4);
        step("b7", 0, 1, 1, 1, 32'hC, 0, 32'h0);
        step("b8", 0, 1, 0, 0, 32'h0, 1, 32'h8);

        // Flush with 8 queued and 12 in flight; redirect to 0x100.
        do_reset(32'h0);
        step("f0", 0, 1, 1, 1, 32'h0,   0, 32'h0);
        step("f1", 0, 1, 1, 1, 32'h4,   0, 32'h0);
        step("f2", 0, 1, 0, 0, 32'h0,   1, 32'h0);
        step("f3", 0, 1, 1, 1, 32'h8,   1, 32'h4);
        step("f4", 0, 1, 1, 1, 32'hC,   0, 32'h0);
        step("f5", 1, 1, 0, 1, 32'h0,   1, 32'h8);
        step("f6", 0, 1, 1, 1, 32'h100, 0, 32'h0);
        step("f7", 0, 1, 1, 1, 32'h104, 0, 32'h0);
        step("f8", 0, 1, 0, 0, 32'h0,   1, 32'h100);

        // Misaligned PC: aligned address issued, sticky error until reset.
        do_reset(32'h22);
        step("m0", 0, 1, 1, 1, 32'h20, 0, 32'h0);
        check("m0.mis", 32'(misalign_err), 32'd0);
        step("m1", 0, 1, 1, 1, 32'h24, 0, 32'h0);
        check("m1.mis", 32'(misalign_err), 32'd1);
        step("m2", 0, 1, 0, 0, 32'h0,  1, 32'h22);
        repeat (4) @(negedge clk);
        check("m.hold", 32'(misalign_err), 32'd1);
        do_reset(32'h0);
        check("m.rst", 32'(misalign_err), 32'd0);
        check("m.rstv", 32'(instr_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
